session_timer_ctrl: RTL and testbench



---
 rtl/session_timer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_session_timer_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/session_timer_ctrl.sv
// -----------------------------------------------------------------------------
// session_timer_ctrl
//
// Countdown sequencer for the trainer's three-digit BCD session time. A start
// request loads the digits (clamping each nibble to 9). A free prescaler then
// produces a tick every TICK_DIV RUN cycles, and each tick decrements the
// digits through a BCD borrow chain. Reaching 000 gives a one-cycle EXPIRE
// state, which drives the `done` pulse.
//
// Build option: define SESSION_TIMER_WARN_EN to build the low-time warning
// comparator. Without it, `warn` is tied low.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle request: load load_val and run (ignored in EXPIRE)
//   pause      one-cycle request: toggle RUN <-> PAUSE
//   clear      one-cycle request: abort to IDLE, zero digits
//   load_val   BCD load value {hundreds, tens, ones}
//   digits     current BCD count (registered)
//   running    high in RUN
//   paused     high in PAUSE
//   tick       one-cycle pulse, coincident with each decremented value
//   done       one-cycle pulse on expiry (the EXPIRE cycle)
//   warn       low-time warning (digits <= 010 while RUN or PAUSE)
// -----------------------------------------------------------------------------
module session_timer_ctrl #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [11:0] load_val,
  output logic [11:0] digits,
  output logic        running,
  output logic        paused,
  output logic        tick,
  output logic        done,
  output logic        warn
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_EXPIRE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   digits_q, digits_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  logic [11:0]   load_clamped;
  logic [11:0]   digits_dec;
  logic          tick_edge;

  function automatic logic [3:0] clamp_nib(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // BCD decrement: a zero digit wraps to 9 and borrows from the next digit up.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, o;
    logic       b;
    {h, t, o} = v;
    b = (o == 4'd0);
    o = b ? 4'd9 : o - 4'd1;
    if (b) begin
      b = (t == 4'd0);
      t = b ? 4'd9 : t - 4'd1;
      if (b) h = h - 4'd1;
    end
    return {h, t, o};
  endfunction

  assign load_clamped = {clamp_nib(load_val[11:8]), clamp_nib(load_val[7:4]),
                         clamp_nib(load_val[3:0])};
  assign digits_dec   = bcd_dec(digits_q);
  assign tick_edge    = (state_q == S_RUN) && (presc_q == PRESC_MAX);

  // NOTE: every signal this block writes gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;

    if (clear) begin
      state_d  = S_IDLE;
      digits_d = 12'h000;
      presc_d  = '0;
    end else if (start && (state_q != S_EXPIRE)) begin
      digits_d = load_clamped;
      presc_d  = '0;
      state_d  = (load_clamped == 12'h000) ? S_EXPIRE : S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: presc_d = '0;
        S_RUN: begin
          if (tick_edge) begin
            presc_d  = '0;
            digits_d = digits_dec;
            tick_d   = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // On an expiring tick, expiry takes precedence over a pause request.
          if (tick_edge && (digits_dec == 12'h000)) state_d = S_EXPIRE;
          else if (pause)                           state_d = S_PAUSE;
        end
        // The prescaler holds here, so a resume continues the partial tick.
        S_PAUSE:  if (pause) state_d = S_RUN;
        S_EXPIRE: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      digits_q <= 12'h000;
      presc_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
    end
  end

`ifdef SESSION_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Plain binary compare is valid on BCD because BCD ordering is monotonic.
  always_comb begin
    warn_d = ((state_d == S_RUN) || (state_d == S_PAUSE)) && (digits_d <= 12'h010);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn_q <= 1'b0;
    else     warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  // Status outputs decode the state register directly, so they stay registered.
  assign digits  = digits_q;
  assign tick    = tick_q;
  assign running = (state_q == S_RUN);
  assign paused  = (state_q == S_PAUSE);
  assign done    = (state_q == S_EXPIRE);

endmodule

// File: tb/tb_session_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_session_timer_ctrl
//
// Scoreboard bench for session_timer_ctrl with TICK_DIV = 4. Stimulus pushes
// the expected {cycle, digits, tick, done, paused, warn} for every tick/done
// event. A negedge monitor pops and compares an entry whenever the DUT shows
// tick or done. Direct checks cover reset values, idle states and clamping.
// -----------------------------------------------------------------------------
module tb_session_timer_ctrl;

  localparam int unsigned TD = 4;
`ifdef SESSION_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [11:0] load_val = 12'h000;
  logic [11:0] digits;
  logic        running, paused, tick, done, warn;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [11:0] digits;
    logic        tick;
    logic        done;
    logic        paused;
    logic        warn;
  } evt_t;

  evt_t sb[$];

  session_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .load_val(load_val), .digits(digits), .running(running), .paused(paused),
    .tick(tick), .done(done), .warn(warn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int c, input logic [11:0] d, input logic tk,
                            input logic dn, input logic pz);
    evt_t e;
    e.cyc = c; e.digits = d; e.tick = tk; e.done = dn; e.paused = pz;
    e.warn = dn ? 1'b0 : (WARN_ON && (d <= 12'h010));
    sb.push_back(e);
  endtask

  // Monitor: compare each tick/done event against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && (tick || done)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {20'd0, digits}, 32'hFFFF_FFFF);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check("evt_cycle",  cyc,    e.cyc);
        check("evt_digits", digits, e.digits);
        check("evt_tick",   tick,   e.tick);
        check("evt_done",   done,   e.done);
        check("evt_paused", paused, e.paused);
        check("evt_warn",   warn,   e.warn);
      end
    end
  end

  // Land on the negedge of cycle c (cycle c = the cycle after cyc became c).
  task automatic goto(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive a one-cycle request; t returns the first cycle showing its effect.
  task automatic pulse(input logic s, input logic p, input logic cl,
                       input logic [11:0] lv, output int t);
    @(negedge clk);
    start = s; pause = p; clear = cl; load_val = lv;
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    t = cyc;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_digits"},  digits,  12'h000);
    check({name, "_running"}, running, 1'b0);
    check({name, "_paused"},  paused,  1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t, t2, pcnt;

    // Reset values, checked asynchronously before the first clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_digits", digits, 12'h000);
    check("rst_running", running, 1'b0);
    check("rst_paused", paused, 1'b0);
    check("rst_tick", tick, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_warn", warn, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic countdown 003 -> 000.
    pulse(1, 0, 0, 12'h003, t);
    expect_evt(t + 4,  12'h002, 1, 0, 0);
    expect_evt(t + 8,  12'h001, 1, 0, 0);
    expect_evt(t + 12, 12'h000, 1, 1, 0);
    goto(t);
    check("load3_digits", digits, 12'h003);
    check("load3_running", running, 1'b1);
    drain("sb_count3");
    goto(t + 13);
    check_idle("after_expire3");
    check("after_expire3_done", done, 1'b0);

    // Borrow chain: 100 -> 099 ... 090, then clear mid-tick.
    pulse(1, 0, 0, 12'h100, t);
    expect_evt(t + 4,  12'h099, 1, 0, 0);
    expect_evt(t + 8,  12'h098, 1, 0, 0);
    expect_evt(t + 12, 12'h097, 1, 0, 0);
    expect_evt(t + 16, 12'h096, 1, 0, 0);
    expect_evt(t + 20, 12'h095, 1, 0, 0);
    expect_evt(t + 24, 12'h094, 1, 0, 0);
    expect_evt(t + 28, 12'h093, 1, 0, 0);
    expect_evt(t + 32, 12'h092, 1, 0, 0);
    expect_evt(t + 36, 12'h091, 1, 0, 0);
    expect_evt(t + 40, 12'h090, 1, 0, 0);
    goto(t + 41);
    pulse(0, 0, 1, 12'h000, t2);
    goto(t2);
    check_idle("after_clear");
    drain("sb_borrow");

    // Pause two cycles into a tick for 10 cycles, then resume.
    pulse(1, 0, 0, 12'h002, t);
    expect_evt(t + 14, 12'h001, 1, 0, 0);
    expect_evt(t + 18, 12'h000, 1, 1, 0);
    pcnt = 0;
    for (int c = t; c < t + 20; c++) begin
      goto(c);
      if (paused) pcnt++;
      if (c == t + 13) check("resume_digits", digits, 12'h002);
      pause = ((c == t + 1) || (c == t + 11));
    end
    pause = 1'b0;
    check("pause_cycles", pcnt, 10);
    drain("sb_pause");

    // Pause on a non-expiring tick: decrement happens, state becomes PAUSE.
    pulse(1, 0, 0, 12'h002, t);
    expect_evt(t + 4, 12'h001, 1, 0, 1);
    goto(t + 2);
    pulse(0, 1, 0, 12'h000, t2);
    goto(t + 6);
    check("tick_pause_paused", paused, 1'b1);
    check("tick_pause_digits", digits, 12'h001);
    pulse(0, 0, 1, 12'h000, t2);
    drain("sb_tick_pause");

    // Start with 000: immediate done, no tick.
    pulse(1, 0, 0, 12'h000, t);
    expect_evt(t, 12'h000, 0, 1, 0);
    goto(t + 1);
    check_idle("zero_load");
    drain("sb_zero");

    // Clamp FAB -> 999.
    pulse(1, 0, 0, 12'hFAB, t);
    goto(t);
    check("clamp_digits", digits, 12'h999);
    check("clamp_running", running, 1'b1);
    pulse(0, 0, 1, 12'h000, t2);

    // Clear and start together: clear wins.
    pulse(1, 0, 0, 12'h050, t);
    goto(t + 1);
    pulse(1, 0, 1, 12'h123, t2);
    goto(t2);
    check_idle("clear_start");

    // Pause on an expiring tick: expiry wins.
    pulse(1, 0, 0, 12'h001, t);
    expect_evt(t + 4, 12'h000, 1, 1, 0);
    goto(t + 2);
    pulse(0, 1, 0, 12'h000, t2);
    goto(t + 5);
    check_idle("expire_pause");
    drain("sb_expire_pause");

    // Async reset mid-RUN at 057: outputs zero immediately, no done.
    pulse(1, 0, 0, 12'h058, t);
    expect_evt(t + 4, 12'h057, 1, 0, 0);
    goto(t + 5);
    check("pre_rst_digits", digits, 12'h057);
    #1 rst = 1'b1;
    #1;
    check("arst_digits", digits, 12'h000);
    check("arst_running", running, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_tick", tick, 1'b0);
    check("arst_warn", warn, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_idle("post_rst");
    check("sb_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
